// File: rtl/clock24_pkg.sv
// Shared definitions for the 24-hour BCD clock: mode encodings, BCD field limits
// and the button decode used by the core.
package clock24_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } smode_e;

    localparam logic [7:0] MOD60 = 8'h59;
    localparam logic [7:0] MOD24 = 8'h23;

    localparam int DEFAULT_CLK_HZ    = 48_000_000;
    localparam int DEFAULT_BLINK_DIV = 2;

    // Button events after priority resolution for the current mode.
    typedef struct packed {
        logic mode;
        logic up;
        logic clr;
    } btn_t;

    // MODE wins over UP in the same cycle; UP only counts in a set state; CLR always applies.
    function automatic btn_t decode_buttons(input logic [2:0] bin, input smode_e state);
        btn_t ev;
        ev.mode = bin[0];
        ev.up   = bin[1] && !bin[0] && (state != RUN);
        ev.clr  = bin[2];
        return ev;
    endfunction

endpackage

// File: rtl/clock24_bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after MAXVAL.
// It raises carry when it is incremented at MAXVAL.
module bcd2_counter
    import clock24_pkg::*;
#(
    parameter logic [7:0] MAXVAL = MOD60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] value_o,
    output logic       carry_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it holding (no latch).
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = 8'h00;
        end else if (inc_i) begin
            if (value_q == MAXVAL) begin
                value_d = 8'h00;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = inc_i && (value_q == MAXVAL);

endmodule

// File: rtl/clock24_core.sv
// 24-hour BCD time-of-day keeper with a button-driven set mode and a display blink request.
// It contains the prescaler, the mode FSM and the carry chain between the three BCD fields.
module clock24_core
    import clock24_pkg::*;
#(
    parameter int CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BIN,
    output logic [7:0] HOUR,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic [1:0] SMODE,
    output logic       BLINK
);

    localparam int BPER = CLK_HZ / BLINK_DIV;
    localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW   = (BPER > 1) ? $clog2(BPER) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(BPER - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BPER / 2);

    smode_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q,  bcnt_d;
    logic          hold_q,  hold_d;

    btn_t ev;
    logic tick1s;
    logic in_run;
    logic exit_set;
    logic restart;

    logic sec_inc,  sec_carry;
    logic min_inc,  min_carry;
    logic hour_inc, hour_carry_unused;

    assign ev       = decode_buttons(BIN, state_q);
    assign tick1s   = (presc_q == PRESC_MAX);
    assign in_run   = (state_q == RUN);
    assign exit_set = ev.mode && (state_q == SET_MIN);
    assign restart  = ev.clr || exit_set;

    always_comb begin
        state_d = state_q;
        BLINK   = 1'b0;
        if (ev.mode) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                default:  state_d = RUN;
            endcase
        end
        if (!in_run && (bcnt_q >= BLINK_HALF) && !hold_q && !ev.up) begin
            BLINK = 1'b1;
        end
    end

    // The blink counter restarts with the prescaler; BLINK_DIV divides CLK_HZ, so both wrap together.
    always_comb begin
        presc_d = presc_q + PW'(1);
        bcnt_d  = bcnt_q + BW'(1);
        if (restart || tick1s) begin
            presc_d = '0;
        end
        if (restart || (bcnt_q == BLINK_MAX)) begin
            bcnt_d = '0;
        end
        hold_d = (ev.up || hold_q) && (bcnt_d != '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RUN;
            presc_q <= '0;
            bcnt_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            hold_q  <= hold_d;
        end
    end

    // Carries only propagate in RUN; in the set states UP edits one field without carry.
    assign sec_inc  = in_run && tick1s && !ev.clr;
    assign min_inc  = (in_run && sec_carry) || ((state_q == SET_MIN) && ev.up);
    assign hour_inc = (in_run && min_carry) || ((state_q == SET_HOUR) && ev.up);

    bcd2_counter #(.MAXVAL(MOD60)) u_sec (
        .clk     (CLK),
        .rst_n   (RST),
        .inc_i   (sec_inc),
        .clr_i   (restart),
        .value_o (SEC),
        .carry_o (sec_carry)
    );

    bcd2_counter #(.MAXVAL(MOD60)) u_min (
        .clk     (CLK),
        .rst_n   (RST),
        .inc_i   (min_inc),
        .clr_i   (1'b0),
        .value_o (MIN),
        .carry_o (min_carry)
    );

    bcd2_counter #(.MAXVAL(MOD24)) u_hour (
        .clk     (CLK),
        .rst_n   (RST),
        .inc_i   (hour_inc),
        .clr_i   (1'b0),
        .value_o (HOUR),
        .carry_o (hour_carry_unused)
    );

    assign SMODE = state_q;

endmodule

// File: tb/tb_clock24_core.sv
// Bench for clock24_core: a seconds-of-day reference model is compared every cycle,
// alongside directed scenarios with literal expectations and a randomized button phase.
module tb_clock24_core;
    import clock24_pkg::*;

    localparam int CLK_HZ    = 10;
    localparam int BLINK_DIV = 2;
    localparam int BPER      = CLK_HZ / BLINK_DIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] BIN = 3'b000;
    logic [7:0] HOUR, MIN, SEC;
    logic [1:0] SMODE;
    logic       BLINK;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    clock24_core #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .BIN   (BIN),
        .HOUR  (HOUR),
        .MIN   (MIN),
        .SEC   (SEC),
        .SMODE (SMODE),
        .BLINK (BLINK)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain integer time fields, prescaler phase and mode number.
    int m_h, m_m, m_s, m_p, m_mode;
    bit m_hold;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit exp_blink();
        bit up;
        up = BIN[1] && !BIN[0] && (m_mode != 0);
        return (m_mode != 0) && ((m_p % BPER) >= (BPER / 2)) && !m_hold && !up;
    endfunction

    always @(posedge CLK or negedge RST) begin : model
        bit mode, up, clr, tick, ex;
        int pn, t;
        if (!RST) begin
            m_h = 0; m_m = 0; m_s = 0; m_p = 0; m_mode = 0; m_hold = 1'b0;
        end else begin
            mode = BIN[0];
            clr  = BIN[2];
            up   = BIN[1] && !mode && (m_mode != 0);
            tick = (m_p == CLK_HZ - 1);
            ex   = mode && (m_mode == 2);
            if (up && m_mode == 1) m_h = (m_h + 1) % 24;
            if (up && m_mode == 2) m_m = (m_m + 1) % 60;
            if (clr || ex) begin
                m_s = 0;
            end else if (m_mode == 0 && tick) begin
                t   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = t / 3600;
                m_m = (t / 60) % 60;
                m_s = t % 60;
            end
            pn     = (clr || ex) ? 0 : (m_p + 1) % CLK_HZ;
            m_hold = (up || m_hold) && ((pn % BPER) != 0);
            m_p    = pn;
            if (mode) m_mode = (m_mode + 1) % 3;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_hour",  HOUR,  to_bcd(m_h));
            check("model_min",   MIN,   to_bcd(m_m));
            check("model_sec",   SEC,   to_bcd(m_s));
            check("model_smode", SMODE, m_mode);
            check("model_blink", BLINK, exp_blink());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One-cycle pulse followed by one idle cycle.
    task automatic press(input logic [2:0] b);
        BIN = b;
        cyc(1);
        BIN = 3'b000;
        cyc(1);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cyc(2);
        RST = 1'b1;
    endtask

    task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        check({name, "_hour"}, HOUR, h);
        check({name, "_min"},  MIN,  m);
        check({name, "_sec"},  SEC,  s);
    endtask

    initial begin
        bit busy;
        int r;
        cyc(2);
        check_time("reset", 8'h00, 8'h00, 8'h00);
        check("reset_smode", SMODE, 2'd0);
        check("reset_blink", BLINK, 1'b0);
        RST    = 1'b1;
        cmp_en = 1'b1;

        cyc(10);
        check_time("first_sec", 8'h00, 8'h00, 8'h01);
        cyc(590);
        check_time("run_600", 8'h00, 8'h01, 8'h00);

        // Preload 23:59:59 and watch the day wrap.
        do_reset();
        press(3'b001);
        check("enter_set_hour", SMODE, 2'd1);
        repeat (23) press(3'b010);
        press(3'b001);
        repeat (59) press(3'b010);
        press(3'b001);
        check_time("preload_exit", 8'h23, 8'h59, 8'h00);
        cyc(589);
        check_time("preload", 8'h23, 8'h59, 8'h59);
        cyc(9);
        check_time("before_wrap", 8'h23, 8'h59, 8'h59);
        cyc(1);
        check_time("day_wrap", 8'h00, 8'h00, 8'h00);

        // Field wrap in set mode without carry, then a full second after exit.
        press(3'b001);
        repeat (25) press(3'b010);
        check("hour_mod24", HOUR, 8'h01);
        press(3'b001);
        repeat (61) press(3'b010);
        check_time("min_mod60", 8'h01, 8'h01, 8'h00);
        press(3'b001);
        check("exit_smode", SMODE, 2'd0);
        check("exit_sec", SEC, 8'h00);
        cyc(8);
        check("exit_sec_hold", SEC, 8'h00);
        cyc(1);
        check("exit_full_second", SEC, 8'h01);

        // MODE and UP together: UP is dropped.
        press(3'b011);
        check("mode_up_smode", SMODE, 2'd1);
        check("mode_up_hour", HOUR, 8'h01);
        press(3'b001);
        press(3'b001);

        // CLR landing on tick1s at SEC=05.
        cyc(58);
        check("pre_clr_sec", SEC, 8'h05);
        press(3'b100);
        check("clr_beats_tick", SEC, 8'h00);
        cyc(8);
        check("clr_sec_hold", SEC, 8'h00);
        cyc(1);
        check("clr_full_second", SEC, 8'h01);

        // Blink timing in SET_HOUR, aligned by CLR.
        check("blink_run", BLINK, 1'b0);
        press(3'b001);
        press(3'b100);
        check("blink_phase1", BLINK, 1'b0);
        cyc(1);
        check("blink_phase2", BLINK, 1'b1);
        cyc(3);
        check("blink_phase0", BLINK, 1'b0);
        cyc(2);
        check("blink_phase2b", BLINK, 1'b1);
        BIN = 3'b010;
        #1;
        check("blink_up_cycle", BLINK, 1'b0);
        cyc(1);
        BIN = 3'b000;
        check("blink_hold3", BLINK, 1'b0);
        cyc(1);
        check("blink_hold4", BLINK, 1'b0);
        cyc(1);
        check("blink_new_period", BLINK, 1'b0);
        cyc(2);
        check("blink_resume", BLINK, 1'b1);
        check("blink_up_hour", HOUR, 8'h02);

        // Asynchronous reset while editing minutes.
        press(3'b001);
        press(3'b010);
        press(3'b010);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check_time("async_rst", 8'h00, 8'h00, 8'h00);
        check("async_rst_smode", SMODE, 2'd0);
        check("async_rst_blink", BLINK, 1'b0);
        cyc(2);
        RST = 1'b1;

        // Random button traffic, pulses always separated by an idle cycle.
        busy = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (busy) begin
                BIN  = 3'b000;
                busy = 1'b0;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 10) begin
                    BIN  = 3'($urandom_range(1, 7));
                    busy = 1'b1;
                end else begin
                    BIN = 3'b000;
                end
            end
            if ($urandom_range(0, 1499) == 0) begin
                RST = 1'b0;
                cyc(1);
                RST = 1'b1;
            end else begin
                cyc(1);
            end
        end
        BIN = 3'b000;
        cyc(2);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
